// File: rtl/sn_write_sched.sv
// Write scheduler for the three SN76489 PSGs: queues CPU writes and plays them out one at a time.
// Optional stuck-strobe abort is enabled by defining SN_WRITE_SCHED_TIMEOUT_EN.
module sn_write_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_14m,
    input  logic                   reset,
    input  logic                   wr_req_i,
    input  logic [1:0]             wr_chip_i,
    input  logic [7:0]             wr_data_i,
    input  logic [2:0]             sn_ready_i,
    output logic [2:0]             sn_ce_n_o,
    output logic [7:0]             sn_d_o,
    output logic                   busy_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   ovf_o,
    output logic                   err_o,
    output logic                   tmo_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    // FIFO storage and pointers
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, busy_q, busy_d;
    logic          ovf_q, err_q;
    logic          push, pop, chip_ok;
    logic [9:0]    head;

    // Write engine
    logic [2:0] state_q, state_d;
    logic [1:0] cur_chip_q, cur_chip_d;
    logic [7:0] sn_d_q, sn_d_d;
    logic [2:0] ce_n_q, ce_n_d;
    logic       ready_sel;

`ifdef SN_WRITE_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
`endif

    // A write request is taken only when the entry can be stored; the engine
    // pops only from IDLE, so a pop always frees a slot for a same-cycle push.
    always_comb begin
        chip_ok = (wr_chip_i != 2'd3);
        pop     = (state_q == S_IDLE) && (level_q != '0);
        push    = wr_req_i && chip_ok && ((level_q != FULL_LVL) || pop);
        head    = mem_q[rptr_q];
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        case (cur_chip_q)
            2'd0:    ready_sel = sn_ready_i[0];
            2'd1:    ready_sel = sn_ready_i[1];
            2'd2:    ready_sel = sn_ready_i[2];
            default: ready_sel = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_chip_d = cur_chip_q;
        sn_d_d     = sn_d_q;
        ce_n_d     = ce_n_q;
`ifdef SN_WRITE_SCHED_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_chip_d = head[9:8];
                    sn_d_d     = head[7:0];
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                ce_n_d  = ~(3'b001 << cur_chip_q);
                state_d = S_STROBE;
`ifdef SN_WRITE_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_STROBE: begin
`ifdef SN_WRITE_SCHED_TIMEOUT_EN
                if (tmo_cnt_q == TMO_LAST) begin
                    ce_n_d  = 3'b111;
                    tmo_d   = 1'b1;
                    state_d = S_RECOVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (!ready_sel) state_d = S_HOLD;
                end
`else
                if (!ready_sel) state_d = S_HOLD;
`endif
            end
            S_HOLD: begin
`ifdef SN_WRITE_SCHED_TIMEOUT_EN
                if (tmo_cnt_q == TMO_LAST) begin
                    ce_n_d  = 3'b111;
                    tmo_d   = 1'b1;
                    state_d = S_RECOVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (ready_sel) begin
                        ce_n_d  = 3'b111;
                        state_d = S_RECOVER;
                    end
                end
`else
                if (ready_sel) begin
                    ce_n_d  = 3'b111;
                    state_d = S_RECOVER;
                end
`endif
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                ce_n_d  = 3'b111;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk_14m) begin
        if (push) mem_q[wptr_q] <= {wr_chip_i, wr_data_i};
    end

    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= S_IDLE;
            cur_chip_q <= 2'd0;
            sn_d_q     <= 8'h00;
            ce_n_q     <= 3'b111;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= (level_d == FULL_LVL);
            busy_q     <= busy_d;
            ovf_q      <= wr_req_i && chip_ok && !push;
            err_q      <= wr_req_i && !chip_ok;
            state_q    <= state_d;
            cur_chip_q <= cur_chip_d;
            sn_d_q     <= sn_d_d;
            ce_n_q     <= ce_n_d;
        end
    end

`ifdef SN_WRITE_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
    assign tmo_o = tmo_q;
`else
    assign tmo_o = 1'b0;
`endif

    assign sn_ce_n_o = ce_n_q;
    assign sn_d_o    = sn_d_q;
    assign busy_o    = busy_q;
    assign full_o    = full_q;
    assign level_o   = level_q;
    assign ovf_o     = ovf_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_sn_write_sched.sv
// Directed bench for sn_write_sched: reset, single write, burst/overflow, error code,
// simultaneous push/pop when full, reset during HOLD, and stuck-strobe behaviour.
module tb_sn_write_sched;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk_14m = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_14m = ~clk_14m;

  logic          wr_req_i   = 1'b0;
  logic [1:0]    wr_chip_i  = 2'd0;
  logic [7:0]    wr_data_i  = 8'h00;
  logic [2:0]    sn_ready_i = 3'b111;
  logic [2:0]    sn_ce_n_o;
  logic [7:0]    sn_d_o;
  logic          busy_o, full_o, ovf_o, err_o, tmo_o;
  logic [LW-1:0] level_o;

  sn_write_sched #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk_14m    (clk_14m),
    .reset      (reset),
    .wr_req_i   (wr_req_i),
    .wr_chip_i  (wr_chip_i),
    .wr_data_i  (wr_data_i),
    .sn_ready_i (sn_ready_i),
    .sn_ce_n_o  (sn_ce_n_o),
    .sn_d_o     (sn_d_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .level_o    (level_o),
    .ovf_o      (ovf_o),
    .err_o      (err_o),
    .tmo_o      (tmo_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic tick();
    @(posedge clk_14m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // waits (bounded) until some enable is low; reports whether it was seen
  task automatic wait_ce(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sn_ce_n_o != 3'b111) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic write1(input logic [1:0] chip, input logic [7:0] data);
    wr_req_i  = 1'b1;
    wr_chip_i = chip;
    wr_data_i = data;
    tick();
    wr_req_i  = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic       seen;
    logic [9:0] e;
    logic [2:0] ce_exp;
    logic [1:0] other;
    logic       first;
    int         n;

    // ---- reset values
    tick(); tick(); tick();
    chk("rst_ce_n", sn_ce_n_o, 3'b111);
    chk("rst_d", sn_d_o, 8'h00);
    chk("rst_level", level_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_flags", {ovf_o, err_o, tmo_o}, 3'b000);
    reset = 1'b0;
    tick();

    // ---- single write {chip 1, 9F}
    write1(2'd1, 8'h9F);
    chk("w1_level_n1", level_o, 1);
    chk("w1_busy_n1", busy_o, 1);
    chk("w1_ce_n1", sn_ce_n_o, 3'b111);
    tick();
    chk("w1_d_n2", sn_d_o, 8'h9F);
    chk("w1_ce_n2", sn_ce_n_o, 3'b111);
    chk("w1_level_n2", level_o, 0);
    tick();
    chk("w1_ce_n3", sn_ce_n_o, 3'b101);
    tick();
    chk("w1_ce_n4", sn_ce_n_o, 3'b101);
    sn_ready_i = 3'b101;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("w1_ce_hold", sn_ce_n_o, 3'b101);
    end
    sn_ready_i = 3'b111;
    tick();
    chk("w1_ce_release", sn_ce_n_o, 3'b111);
    chk("w1_busy_recover", busy_o, 1);
    tick();
    chk("w1_busy_done", busy_o, 0);
    chk("w1_level_done", level_o, 0);
    chk("w1_d_held", sn_d_o, 8'h9F);

    // ---- chip code 3 is rejected
    write1(2'd3, 8'h55);
    chk("err_pulse", err_o, 1);
    chk("err_ovf", ovf_o, 0);
    chk("err_level", level_o, 0);
    chk("err_busy", busy_o, 0);
    tick();
    chk("err_clear", err_o, 0);
    chk("err_no_ce", sn_ce_n_o, 3'b111);

    // ---- burst of 10, ready idle: FSM holds entry 0, queue fills, last drops
    for (int i = 0; i < 10; i++) begin
      wr_req_i  = 1'b1;
      wr_chip_i = 2'(i % 3);
      wr_data_i = 8'hA0 + 8'(i);
      tick();
      if (i < 9) exp_q.push_back({2'(i % 3), 8'hA0 + 8'(i)});
      n = (i == 0) ? 1 : ((i > 8) ? 8 : i);
      chk("burst_level", level_o, n);
      chk("burst_full", full_o, (n == 8) ? 1 : 0);
      chk("burst_ovf", ovf_o, (i == 9) ? 1 : 0);
    end
    // chip 3 while full: err wins over ovf
    wr_chip_i = 2'd3;
    wr_data_i = 8'h55;
    tick();
    wr_req_i = 1'b0;
    chk("full_err", err_o, 1);
    chk("full_err_no_ovf", ovf_o, 0);
    chk("full_err_level", level_o, 8);
    tick();
    chk("flags_clear", {ovf_o, err_o}, 2'b00);

    // ---- drain in order, with a push on the pop cycle while full
    first = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      ce_exp = ~(3'b001 << e[9:8]);
      other = (e[9:8] == 2'd2) ? 2'd0 : e[9:8] + 2'd1;
      wait_ce(seen);
      chk("drain_ce_seen", seen, 1);
      chk("drain_ce", sn_ce_n_o, ce_exp);
      chk("drain_data", sn_d_o, e[7:0]);
      sn_ready_i = ~(3'b001 << other);
      tick(); tick();
      chk("drain_other_ignored", sn_ce_n_o, ce_exp);
      sn_ready_i = ce_exp;
      tick();
      chk("drain_hold", sn_ce_n_o, ce_exp);
      sn_ready_i = 3'b111;
      tick();
      chk("drain_release", sn_ce_n_o, 3'b111);
      if (first) begin
        first = 1'b0;
        tick();
        chk("pp_full_before", level_o, 8);
        wr_req_i  = 1'b1;
        wr_chip_i = 2'd2;
        wr_data_i = 8'h77;
        tick();
        wr_req_i  = 1'b0;
        exp_q.push_back({2'd2, 8'h77});
        chk("pp_level", level_o, 8);
        chk("pp_full", full_o, 1);
        chk("pp_no_ovf", ovf_o, 0);
      end
    end
    tick();
    chk("drain_busy", busy_o, 0);
    chk("drain_level", level_o, 0);

    // ---- reset during HOLD
    write1(2'd0, 8'h3C);
    write1(2'd2, 8'h11);
    wait_ce(seen);
    chk("rh_ce_seen", seen, 1);
    chk("rh_data", sn_d_o, 8'h3C);
    sn_ready_i = 3'b110;
    tick();
    chk("rh_hold_ce", sn_ce_n_o, 3'b110);
    chk("rh_level", level_o, 1);
    reset = 1'b1;
    #1;
    chk("rh_ce_async", sn_ce_n_o, 3'b111);
    chk("rh_level_async", level_o, 0);
    chk("rh_busy_async", busy_o, 0);
    chk("rh_d_async", sn_d_o, 8'h00);
    tick(); tick();
    sn_ready_i = 3'b111;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rh_no_strobe", sn_ce_n_o, 3'b111);
      chk("rh_idle", busy_o, 0);
    end

    // ---- ready stuck idle
    write1(2'd1, 8'h21);
    write1(2'd2, 8'h42);
    wait_ce(seen);
    chk("st_ce_seen", seen, 1);
    n = 0;
    while (sn_ce_n_o != 3'b111 && n < 40) begin
      n++;
      tick();
    end
`ifdef SN_WRITE_SCHED_TIMEOUT_EN
    chk("tmo_len", n, 16);
    chk("tmo_pulse", tmo_o, 1);
    tick();
    chk("tmo_pulse_end", tmo_o, 0);
    wait_ce(seen);
    chk("tmo_next_seen", seen, 1);
    chk("tmo_next_ce", sn_ce_n_o, 3'b011);
    chk("tmo_next_data", sn_d_o, 8'h42);
`else
    chk("stuck_len", n, 40);
    chk("stuck_ce", sn_ce_n_o, 3'b101);
    chk("stuck_no_tmo", tmo_o, 0);
    chk("stuck_level", level_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
